mul_div_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit (MDU) in the EX stage, beside the ALU.

---
 rtl/mul_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle multiply/divide unit sitting beside the ALU in EX. Runs
//   mult/multu/madd/div/divu into the HI/LO pair and takes single-cycle
//   mthi/mtlo writes. While an operation is in flight, busy is high so hazard
//   logic can stall mfhi/mflo and further MDU ops. cancel blocks issue in the
//   cycle a later stage takes an exception; it never touches an accepted op.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous reset, active-low
//   start   in   issue strobe, qualified by !busy && !cancel
//   op      in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd
//   A, B    in   rs / rt operands
//   cancel  in   issue suppression from M/W
//   busy    out  operation in flight
//   HI, LO  out  architectural HI/LO registers
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  // Returns {remainder, quotient}. Signed division works on magnitudes and
  // restores signs afterwards: quotient truncates toward zero, remainder
  // follows the dividend. Most-negative / -1 falls out naturally as
  // quotient = most-negative, remainder = 0 (the negation wraps).
  function automatic logic [2*WIDTH-1:0] div_result(
    input logic             is_signed,
    input logic [WIDTH-1:0] dividend,
    input logic [WIDTH-1:0] divisor
  );
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    neg_a = is_signed & dividend[WIDTH-1];
    neg_b = is_signed & divisor[WIDTH-1];
    mag_a = neg_a ? -dividend : dividend;
    mag_b = neg_b ? -divisor  : divisor;
    quo   = mag_a / mag_b;
    rem   = mag_a % mag_b;
    if (neg_a ^ neg_b) quo = -quo;
    if (neg_a)         rem = -rem;
    return {rem, quo};
  endfunction

  // ---- p0: issue qualification ----
  logic accept;
  logic is_mul_op;
  logic is_div_op;

  assign accept    = start & ~busy & ~cancel & (op != OP_NONE);
  assign is_mul_op = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_MADD);
  assign is_div_op = (op == OP_DIV)  | (op == OP_DIVU);

  // ---- p1: captured operation and latency counter ----
  logic [CNT_W-1:0] cnt_p1;
  logic [2:0]       op_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic             done_p1;

  assign busy    = (cnt_p1 != '0);
  assign done_p1 = (cnt_p1 == CNT_W'(1));

  // Operands are pure data; op_p1/cnt_p1 decide whether they are ever used.
  always_ff @(posedge clk) begin
    if (accept && (is_mul_op || is_div_op)) begin
      a_p1 <= A;
      b_p1 <= B;
    end
  end

  // ---- p2: result formation, consumed on the counter's 1->0 edge ----
  logic signed [2*WIDTH-1:0] a_sx_p2;
  logic signed [2*WIDTH-1:0] b_sx_p2;
  logic signed [2*WIDTH-1:0] prod_s_p2;
  logic        [2*WIDTH-1:0] prod_u_p2;
  logic        [2*WIDTH-1:0] res_p2;
  logic                      wr_p2;

  assign a_sx_p2   = {{WIDTH{a_p1[WIDTH-1]}}, a_p1};
  assign b_sx_p2   = {{WIDTH{b_p1[WIDTH-1]}}, b_p1};
  assign prod_s_p2 = a_sx_p2 * b_sx_p2;
  assign prod_u_p2 = {{WIDTH{1'b0}}, a_p1} * {{WIDTH{1'b0}}, b_p1};

  always_comb begin
    res_p2 = {HI, LO};
    wr_p2  = 1'b0;
    case (op_p1)
      OP_MULT: begin
        res_p2 = $unsigned(prod_s_p2);
        wr_p2  = 1'b1;
      end
      OP_MULTU: begin
        res_p2 = prod_u_p2;
        wr_p2  = 1'b1;
      end
      OP_MADD: begin
        res_p2 = {HI, LO} + $unsigned(prod_s_p2);
        wr_p2  = 1'b1;
      end
      OP_DIV: begin
        // A zero divisor leaves HI/LO untouched after the full latency.
        if (b_p1 != '0) begin
          res_p2 = div_result(1'b1, a_p1, b_p1);
          wr_p2  = 1'b1;
        end
      end
      OP_DIVU: begin
        if (b_p1 != '0) begin
          res_p2 = div_result(1'b0, a_p1, b_p1);
          wr_p2  = 1'b1;
        end
      end
      default: begin
        res_p2 = {HI, LO};
        wr_p2  = 1'b0;
      end
    endcase
  end

  // Accept and countdown are mutually exclusive because accept needs !busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p1 <= '0;
      op_p1  <= OP_NONE;
      HI     <= '0;
      LO     <= '0;
    end else if (accept) begin
      case (op)
        OP_MTHI: HI <= A;
        OP_MTLO: LO <= A;
        OP_MULT, OP_MULTU, OP_MADD: begin
          cnt_p1 <= CNT_W'(MUL_LAT);
          op_p1  <= op;
        end
        OP_DIV, OP_DIVU: begin
          cnt_p1 <= CNT_W'(DIV_LAT);
          op_p1  <= op;
        end
        default: ;
      endcase
    end else if (busy) begin
      cnt_p1 <= cnt_p1 - CNT_W'(1);
      if (done_p1) begin
        if (wr_p2) {HI, LO} <= res_p2;
        op_p1 <= OP_NONE;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
//   Table of hand-derived vectors, hand-written multi-cycle sequences, and a
//   short random run checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          cancel;
  logic          busy;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  mul_div_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .cancel (cancel),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  logic [W-1:0] hm = '0;
  logic [W-1:0] lm = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got %h_%h expected entry", name, HI, LO);
    end else begin
      e = sb.pop_front();
      chk({name, " HI"}, HI, e.hi);
      chk({name, " LO"}, LO, e.lo);
    end
  endtask

  // Counts negedges with busy high; returns at the first negedge busy is low.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, b,
                                           input logic [W-1:0] hi, lo);
    logic [2*W-1:0] p;
    int sa, sb_, q, r;
    p = longint'($signed(a)) * longint'($signed(b));
    case (o)
      3'd1: return p;
      3'd2: return {32'b0, a} * {32'b0, b};
      3'd7: return {hi, lo} + p;
      3'd3: begin
        if (b == 0) return {hi, lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a); sb_ = $signed(b);
        q = sa / sb_; r = sa % sb_;
        return {r, q};
      end
      3'd4: begin
        if (b == 0) return {hi, lo};
        return {a % b, a / b};
      end
      3'd5: return {a, lo};
      3'd6: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2 || o == 3'd7) return ML;
    if (o == 3'd3 || o == 3'd4) return DL;
    return 0;
  endfunction

  task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] a, b,
                     input logic [W-1:0] eh, el, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    sb.push_back('{hi: eh, lo: el});
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(n);
    chk_int({name, " busy cycles"}, n, lat);
    check_pop(name);
    hm = eh;
    lm = el;
  endtask

  initial begin
    int n, m;
    logic [2:0] ops[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [2:0] o;
    logic [W-1:0] a, b;
    logic [2*W-1:0] r;

    tbl.push_back('{3'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, ML});
    tbl.push_back('{3'd2, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB, ML});
    tbl.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DL});
    tbl.push_back('{3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DL});
    tbl.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DL});
    tbl.push_back('{3'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, DL});
    tbl.push_back('{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DL});
    tbl.push_back('{3'd6, 32'hFFFF_FFFF, 32'd0,         32'h0000_0001, 32'hFFFF_FFFF, 0});
    tbl.push_back('{3'd5, 32'h0000_0000, 32'd0,         32'h0000_0000, 32'hFFFF_FFFF, 0});
    tbl.push_back('{3'd7, 32'd1,         32'd1,         32'h0000_0001, 32'h0000_0000, ML});
    tbl.push_back('{3'd7, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, ML});
    tbl.push_back('{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, ML});
    tbl.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, ML});
    tbl.push_back('{3'd3, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, DL});
    tbl.push_back('{3'd4, 32'd7,         32'd0,         32'hFFFF_FFFE, 32'h0000_0002, DL});

    rst_n = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    rst_n = 1'b1;

    // ---- table vectors ----
    for (int i = 0; i < tbl.size(); i++)
      run($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].lat);

    // ---- reset during busy cycle 2 of a multiply ----
    @(negedge clk);
    start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset HI", HI, 32'd0);
    chk("midreset LO", LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("postreset busy", {31'b0, busy}, 32'd0);
    chk("postreset HI", HI, 32'd0);
    chk("postreset LO", LO, 32'd0);
    hm = '0; lm = '0;

    // ---- start with cancel is ignored ----
    @(negedge clk);
    start = 1'b1; op = 3'd1; A = 32'd9; B = 32'd9; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd0; cancel = 1'b0;
    chk("cancel mult busy", {31'b0, busy}, 32'd0);
    start = 1'b1; op = 3'd5; A = 32'h55; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd0; cancel = 1'b0;
    repeat (6) @(negedge clk);
    chk("cancel busy", {31'b0, busy}, 32'd0);
    chk("cancel HI", HI, 32'd0);
    chk("cancel LO", LO, 32'd0);

    // ---- mthi while busy is ignored; cancel on an in-flight op is harmless ----
    @(negedge clk);
    start = 1'b1; op = 3'd1; A = 32'd5; B = 32'd6;
    sb.push_back('{hi: 32'd0, lo: 32'd30});
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    n = 0;
    if (busy) n++;
    start = 1'b1; op = 3'd5; A = 32'h1234;
    @(negedge clk);
    if (busy) n++;
    start = 1'b0; op = 3'd0; cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    wait_idle(m);
    chk_int("busy-mthi busy cycles", n + m, ML);
    check_pop("busy-mthi");

    // ---- back-to-back issue on the first idle cycle ----
    @(negedge clk);
    start = 1'b1; op = 3'd1; A = 32'd2; B = 32'd3;
    sb.push_back('{hi: 32'd0, lo: 32'd6});
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(n);
    chk_int("b2b first busy cycles", n, ML);
    check_pop("b2b first");
    start = 1'b1; op = 3'd1; A = 32'd4; B = 32'd5;
    sb.push_back('{hi: 32'd0, lo: 32'd20});
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    chk("b2b reassert busy", {31'b0, busy}, 32'd1);
    chk("b2b hold LO", LO, 32'd6);
    wait_idle(n);
    chk_int("b2b second busy cycles", n, ML);
    check_pop("b2b second");
    hm = 32'd0; lm = 32'd20;

    // ---- random operations against the model ----
    for (int i = 0; i < 10; i++) begin
      o = ops[$urandom_range(0, 4)];
      a = $urandom();
      b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 300)));
      r = model(o, a, b, hm, lm);
      run($sformatf("rand%0d", i), o, a, b, r[2*W-1:W], r[W-1:0], lat_of(o));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
